// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// held-instruction hand-off channel towards decode.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: request, wait for data, hold for decode,
// then advance the PC; a misaligned next PC parks the unit in a sticky fault.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_next,
  output logic [31:0]       pc_cur,
  output logic              fault,
  output logic [31:0]       retired_cnt,
  pc_fetch_if.master        bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        fault_r;
  logic [31:0] retired_cnt_r;
  logic        capture_s;
  logic        handoff_s;
  logic        aligned_s;

  // Next-state decode and the capture/hand-off strobes derived from the current state.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    handoff_s    = 1'b0;
    aligned_s    = (pc_next[1:0] == 2'b00);
    case (state_r)
      S_REQ: begin
        if (bus.imem_gnt) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          capture_s    = 1'b1;
          state_next_s = S_HOLD;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          handoff_s = 1'b1;
          if (aligned_s) begin
            state_next_s = S_REQ;
          end else begin
            state_next_s = S_FAULT;
          end
        end else begin
          state_next_s = S_HOLD;
        end
      end
      S_FAULT: begin
        state_next_s = S_FAULT;
      end
      default: begin
        state_next_s = S_REQ;
      end
    endcase
  end

  // State, PC, held instruction, fault flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_REQ;
      pc_r          <= RESET_PC;
      inst_r        <= 32'h0000_0000;
      inst_pc_r     <= 32'h0000_0000;
      fault_r       <= 1'b0;
      retired_cnt_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (capture_s) begin
        inst_r    <= bus.imem_rdata;
        inst_pc_r <= pc_r;
      end
      if (handoff_s) begin
        // Counter wraps silently; a misaligned target still retires the held word.
        retired_cnt_r <= retired_cnt_r + 32'd1;
        if (aligned_s) begin
          pc_r <= pc_next;
        end else begin
          fault_r <= 1'b1;
        end
      end
    end
  end

  // Outputs are direct decodes of registered state, so no combinational input-to-output path.
  assign bus.imem_req   = (state_r == S_REQ);
  assign bus.imem_addr  = pc_r;
  assign bus.inst_valid = (state_r == S_HOLD);
  assign bus.inst       = inst_r;
  assign bus.inst_pc    = inst_pc_r;
  assign pc_cur         = pc_r;
  assign fault          = fault_r;
  assign retired_cnt    = retired_cnt_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: one task per scenario, expectations hand-computed.
module tb_pc_fetch;
  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic [31:0] pc_cur;
  logic        fault;
  logic [31:0] retired_cnt;
  int          errors;
  int          checks;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_next     (pc_next),
    .pc_cur      (pc_cur),
    .fault       (fault),
    .retired_cnt (retired_cnt),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // plain report helper is avoided; comparisons are inline in each test
  endtask

  task automatic idle_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    bus.inst_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_next = 32'h0000_0000;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (pc_cur !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc act=%h exp=%h", pc_cur, 32'h0000_3000); end
    checks++; if (bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL reset_addr act=%h exp=%h", bus.imem_addr, 32'h0000_3000); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req act=%b exp=1", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", bus.inst_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault act=%b exp=0", fault); end
    checks++; if (retired_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt act=%h exp=0", retired_cnt); end
    checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst act=%h/%h exp=0/0", bus.inst, bus.inst_pc); end
    rst = 1'b0;
  endtask

  task automatic test_basic_loop();
    logic [31:0] exp_pc;
    exp_pc = 32'h0000_3000;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.inst_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.imem_rdata = 32'h1000_0000 + k;
      pc_next        = exp_pc + 32'd4;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin errors++; $display("FAIL loop_req k=%0d act=%b/%h exp=1/%h", k, bus.imem_req, bus.imem_addr, exp_pc); end
      checks++; if (retired_cnt !== k) begin errors++; $display("FAIL loop_cnt k=%0d act=%0d exp=%0d", k, retired_cnt, k); end
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL loop_wait_req k=%0d act=%b exp=0", k, bus.imem_req); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h1000_0000 + k || bus.inst_pc !== exp_pc) begin
        errors++; $display("FAIL loop_hold k=%0d act=%b/%h/%h exp=1/%h/%h", k, bus.inst_valid, bus.inst, bus.inst_pc, 32'h1000_0000 + k, exp_pc);
      end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    checks++; if (retired_cnt !== 32'd3 || bus.imem_addr !== 32'h0000_300C) begin errors++; $display("FAIL loop_end act=%0d/%h exp=3/0000300c", retired_cnt, bus.imem_addr); end
    idle_inputs();
  endtask

  task automatic test_hold_stall();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rdata  = 32'hAAAA_5555;
    bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      pc_next = (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000;
      tick();
      checks++; if (bus.inst !== 32'hAAAA_5555 || bus.inst_pc !== 32'h0000_300C || pc_cur !== 32'h0000_300C || bus.inst_valid !== 1'b1) begin
        errors++; $display("FAIL hold_stable i=%0d act=%h/%h/%h/%b exp=aaaa5555/0000300c/0000300c/1", i, bus.inst, bus.inst_pc, pc_cur, bus.inst_valid);
      end
    end
    pc_next        = 32'h0000_4444;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    checks++; if (pc_cur !== 32'h0000_4444 || retired_cnt !== 32'd4 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL hold_release act=%h/%0d/%b exp=00004444/4/1", pc_cur, retired_cnt, bus.imem_req);
    end
  endtask

  task automatic test_stalls();
    int handshakes;
    do_reset();
    handshakes = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL gnt_stall i=%0d act=%b/%h exp=1/00003000", i, bus.imem_req, bus.imem_addr); end
      tick();
    end
    // rvalid in the grant cycle must not be taken
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    if (bus.imem_req === 1'b1) handshakes++;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) handshakes++;
      checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rvalid_stall i=%0d act=%b/%b exp=0/0", i, bus.imem_req, bus.inst_valid); end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
    end
    bus.imem_rdata  = 32'h2408_0005;
    bus.imem_rvalid = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.inst !== 32'h2408_0005 || bus.inst_pc !== 32'h0000_3000 || bus.inst_valid !== 1'b1) begin
      errors++; $display("FAIL stall_capture act=%h/%h/%b exp=24080005/00003000/1", bus.inst, bus.inst_pc, bus.inst_valid);
    end
    checks++; if (handshakes !== 1) begin errors++; $display("FAIL stall_requests act=%0d exp=1", handshakes); end
    pc_next        = 32'h0000_3004;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    checks++; if (pc_cur !== 32'h0000_3004 || retired_cnt !== 32'd1) begin errors++; $display("FAIL stall_handoff act=%h/%0d exp=00003004/1", pc_cur, retired_cnt); end
  endtask

  task automatic test_fault();
    do_reset();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    tick();
    bus.imem_rvalid = 1'b0;
    pc_next         = 32'h0000_3002;
    bus.inst_ready  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || retired_cnt !== 32'd1 || pc_cur !== 32'h0000_3000) begin
        errors++; $display("FAIL fault_state i=%0d act=%b/%b/%b/%0d/%h exp=1/0/0/1/00003000", i, fault, bus.imem_req, bus.inst_valid, retired_cnt, pc_cur);
      end
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.inst_ready  = 1'b1;
      pc_next         = 32'h0000_3004;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++; if (fault !== 1'b0 || bus.imem_req !== 1'b1 || retired_cnt !== 32'd0) begin errors++; $display("FAIL fault_clear act=%b/%b/%0d exp=0/1/0", fault, bus.imem_req, retired_cnt); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rstwait_inwait act=%b exp=0", bus.imem_req); end
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) begin
      errors++; $display("FAIL rstwait_stale act=%b/%h/%b/%h exp=1/00003000/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retired_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_r;
    checks++; if (retired_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload act=%h exp=ffffffff", retired_cnt); end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    pc_next         = 32'h0000_3004;
    bus.inst_ready  = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    checks++; if (retired_cnt !== 32'h0 || fault !== 1'b0 || pc_cur !== 32'h0000_3004) begin
      errors++; $display("FAIL wrap act=%h/%b/%h exp=0/0/00003004", retired_cnt, fault, pc_cur);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    pc_next = 32'h0;
    test_reset();
    test_basic_loop();
    test_hold_stall();
    test_stalls();
    test_fault();
    test_reset_in_wait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC SHALL be RESET_PC, default 32'h0000_3000, the PC loaded on reset.
REQ-002 Port clk SHALL be clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 Port rst SHALL be rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port pc_next SHALL be pc_next, input, 32 bits: next PC from next-PC logic, sampled only on an instruction hand-off.
REQ-005 Port pc_cur SHALL be pc_cur, output, 32 bits: registered current PC, fed to next-PC logic.
REQ-006 Port imem_req SHALL be imem_req, output, 1 bit: instruction-memory read request.
REQ-007 Port imem_addr SHALL be imem_addr, output, 32 bits: read address, equal to pc_cur.
REQ-008 Port imem_gnt SHALL be imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-009 Port imem_rvalid SHALL be imem_rvalid, input, 1 bit: read data valid.
REQ-010 Port imem_rdata SHALL be imem_rdata, input, 32 bits: instruction word.
REQ-011 Port inst_valid SHALL be inst_valid, output, 1 bit: instruction held for decode.
REQ-012 Port inst SHALL be inst, output, 32 bits: held instruction word.
REQ-013 Port inst_pc SHALL be inst_pc, output, 32 bits: PC of the held instruction.
REQ-014 Port inst_ready SHALL be inst_ready, input, 1 bit: decode consumes the held instruction.
REQ-015 Port fault SHALL be fault, output, 1 bit: sticky misaligned-PC fault.
REQ-016 Port retired_cnt SHALL be retired_cnt, output, 32 bits: count of instructions handed off.

Function
REQ-017 The FSM SHALL have four states: REQ, WAIT, HOLD, FAULT.
REQ-018 In REQ, imem_req SHALL be 1; imem_gnt=1 SHALL move to WAIT next cycle; otherwise stay in REQ.
REQ-019 imem_req SHALL be 0 in WAIT, HOLD and FAULT; imem_addr SHALL always equal pc_cur.
REQ-020 In WAIT, imem_rvalid=1 SHALL capture imem_rdata into inst and pc_cur into inst_pc, then move to HOLD.
REQ-021 imem_rvalid SHALL be ignored in every state except WAIT, including a stale response after reset.
REQ-022 In HOLD, inst_valid SHALL be 1; inst, inst_pc and pc_cur SHALL be stable until hand-off.
REQ-023 Hand-off SHALL occur when inst_valid=1 and inst_ready=1.
REQ-024 At hand-off with pc_next[1:0]=2'b00, pc_cur SHALL load pc_next, retired_cnt SHALL increment, and the FSM SHALL move to REQ.
REQ-025 At hand-off with pc_next[1:0]!=2'b00, retired_cnt SHALL increment, pc_cur SHALL hold, fault SHALL be set and the FSM SHALL move to FAULT.
REQ-026 FAULT SHALL be absorbing until rst; inst_valid SHALL be 0 there.
REQ-027 inst_ready SHALL be ignored outside HOLD.
REQ-028 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-029 Minimum loop SHALL be 3 cycles per instruction (gnt in REQ cycle, rvalid first WAIT cycle, ready first HOLD cycle); imem_rvalid SHALL NOT be accepted in the gnt cycle.
REQ-030 A stalled gnt, rvalid or inst_ready SHALL extend the matching state indefinitely with no loss of state.

Reset
REQ-031 On rst=1 at a clock edge, next state SHALL be REQ; pc_cur SHALL be RESET_PC; inst, inst_pc SHALL be 0; inst_valid, fault SHALL be 0; retired_cnt SHALL be 0.
REQ-032 rst SHALL take priority over every other input in any state, including mid-WAIT and FAULT.

Verification
REQ-033 Release rst, gnt and rvalid tied 1, ready 1, pc_next=pc_cur+4 -> imem_addr 0x3000, 0x3004, 0x3008 on 3-cycle spacing; retired_cnt 1, 2, 3.
REQ-034 In HOLD, ready=0 for 5 cycles, pc_next toggled -> inst, inst_pc, pc_cur unchanged; then ready=1 -> pc_cur takes pc_next sampled that cycle.
REQ-035 gnt=0 for 4 cycles, then 1; rvalid delayed 3 cycles with rdata=0x2408_0005 -> inst=0x2408_0005, inst_pc=0x3000, one request only.
REQ-036 At hand-off, pc_next=0x0000_3002 -> fault=1, imem_req=0, inst_valid=0, retired_cnt=1; stays so until rst.
REQ-037 Assert rst in WAIT, then rvalid=1 in the first cycle after reset release -> response ignored, new request to 0x3000, inst_valid=0.
REQ-038 Force retired_cnt to 0xFFFF_FFFF, perform one hand-off -> retired_cnt=0, fault=0.
